debugger_apb_sequencer: RTL and testbench

//  APB3 slave front end for the debugger microcode ROM. Decodes PADDR into the ROM index,

---
 rtl/debugger_apb_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_debugger_apb_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/debugger_apb_sequencer.sv
// APB3 slave front end for the debugger microcode ROM: halts the CPU, steps the ROM
// until it signals the last step, then completes the APB transfer with read data or an error.
module debugger_apb_sequencer #(
  parameter int PADDR_W   = 16,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int MAX_STEPS = 4,
  localparam int STEP_W   = $clog2(MAX_STEPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [PADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0]  pwdata,
  output logic [DATA_W-1:0]  prdata,
  output logic               pready,
  output logic               pslverr,
  output logic               halt_req,
  input  logic               halt_ack,
  output logic [ADDR_W-1:0]  uc_addr,
  output logic               uc_write,
  output logic [STEP_W-1:0]  uc_step,
  input  logic               uc_pready,
  input  logic               uc_paddr_or_pwdata,
  input  logic               uc_outreg_or_bus,
  output logic               dbg_active,
  output logic [DATA_W-1:0]  dbg_bus_out,
  input  logic [DATA_W-1:0]  dbg_bus_in,
  input  logic [DATA_W-1:0]  outreg_in
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HALT = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic                halt_q, halt_d;
  logic [STEP_W-1:0]   step_q, step_d;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      halt_q    <= 1'b0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      halt_q    <= halt_d;
      step_q    <= step_d;
    end
  end

  // Next-state logic; pready/pslverr are recomputed every cycle so they drop on exit.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    halt_d    = halt_q;
    step_d    = step_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr[ADDR_W-1:0];
          write_d = pwrite;
          wdata_d = pwdata;
          step_d  = '0;
          if (paddr[PADDR_W-1:ADDR_W] != '0) begin
            state_d = ERR;
          end else begin
            halt_d  = 1'b1;
            state_d = HALT;
          end
        end else begin
          halt_d = 1'b0;
        end
      end
      HALT: begin
        if (!psel) begin
          state_d = IDLE;
          halt_d  = 1'b0;
        end else if (halt_ack) begin
          state_d = RUN;
          step_d  = '0;
        end else begin
          state_d = HALT;
        end
      end
      RUN: begin
        // halt_ack is deliberately not looked at here: once running, the ROM sequence finishes.
        if (!psel) begin
          state_d = IDLE;
          halt_d  = 1'b0;
          step_d  = '0;
        end else if (uc_pready) begin
          if (!write_q) begin
            prdata_d = uc_outreg_or_bus ? outreg_in : dbg_bus_in;
          end else begin
            prdata_d = prdata_q;
          end
          state_d  = DONE;
          pready_d = 1'b1;
        end else if (step_q == LAST_STEP) begin
          state_d   = ERR;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      DONE, ERR: begin
        if (!psel || (penable && pready_q)) begin
          state_d = IDLE;
          halt_d  = 1'b0;
          step_d  = '0;
        end else begin
          pready_d  = 1'b1;
          pslverr_d = (state_q == ERR);
        end
      end
      default: begin
        state_d = IDLE;
        halt_d  = 1'b0;
        step_d  = '0;
      end
    endcase
  end

  assign prdata     = prdata_q;
  assign pready     = pready_q;
  assign pslverr    = pslverr_q;
  assign halt_req   = halt_q;
  assign uc_addr    = addr_q;
  assign uc_write   = write_q;
  assign uc_step    = step_q;
  assign dbg_active = (state_q == RUN);

  // The ROM selects per step between the address byte (index rebased by 8) and the write data.
  always_comb begin
    if (state_q == RUN) begin
      if (uc_paddr_or_pwdata) begin
        dbg_bus_out = {{(DATA_W-ADDR_W){1'b0}}, addr_q - ADDR_W'(8)};
      end else begin
        dbg_bus_out = wdata_q;
      end
    end else begin
      dbg_bus_out = '0;
    end
  end

endmodule

// File: tb/tb_debugger_apb_sequencer.sv
// Directed self-checking bench for debugger_apb_sequencer with a small microcode ROM model.
module tb_debugger_apb_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       psel, penable, pwrite;
  logic [15:0] paddr;
  logic [7:0] pwdata, prdata;
  logic       pready, pslverr, halt_req, halt_ack;
  logic [4:0] uc_addr;
  logic       uc_write;
  logic [1:0] uc_step;
  logic       uc_pready, uc_paddr_or_pwdata, uc_outreg_or_bus;
  logic       dbg_active;
  logic [7:0] dbg_bus_out, dbg_bus_in, outreg_in;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  debugger_apb_sequencer dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .halt_req(halt_req), .halt_ack(halt_ack), .uc_addr(uc_addr), .uc_write(uc_write),
    .uc_step(uc_step), .uc_pready(uc_pready), .uc_paddr_or_pwdata(uc_paddr_or_pwdata),
    .uc_outreg_or_bus(uc_outreg_or_bus), .dbg_active(dbg_active), .dbg_bus_out(dbg_bus_out),
    .dbg_bus_in(dbg_bus_in), .outreg_in(outreg_in)
  );

  // Microcode ROM model: per-entry step behaviour; unlisted entries never raise PREADY.
  always_comb begin
    uc_pready          = 1'b0;
    uc_paddr_or_pwdata = 1'b0;
    uc_outreg_or_bus   = 1'b0;
    case (uc_addr)
      5'h01: uc_pready = 1'b1;
      5'h0A: begin
        if (uc_step == 2'd0) uc_paddr_or_pwdata = 1'b1;
        else uc_pready = 1'b1;
      end
      5'h07: begin
        uc_pready        = 1'b1;
        uc_outreg_or_bus = 1'b1;
      end
      5'h02: uc_pready = 1'b1;
      default: uc_pready = 1'b0;
    endcase
  end

  assign dbg_bus_in = (uc_step == 2'd1) ? 8'h33 : 8'h99;
  assign outreg_in  = 8'hC4;

  // Transfer results gathered by run_xfer.
  int         nrun;
  logic [7:0] bus0, bus1;
  logic       saw_ready, got_slverr, halt_seen, first_pready, run_when_free;

  task automatic run_xfer(input logic [15:0] a, input logic wr, input logic [7:0] wd,
                          input int ack_delay, input logic drop_ack);
    int hcnt = 0;
    nrun = 0; bus0 = 8'h00; bus1 = 8'h00;
    saw_ready = 1'b0; got_slverr = 1'b0; halt_seen = 1'b0; run_when_free = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 0) first_pready = pready;
      if (halt_req) begin
        halt_seen = 1'b1;
        hcnt++;
      end
      if (dbg_active) begin
        nrun++;
        if (!halt_req) run_when_free = 1'b1;
        if (uc_step == 2'd0) bus0 = dbg_bus_out;
        if (uc_step == 2'd1) bus1 = dbg_bus_out;
        if (drop_ack) halt_ack = 1'b0;
      end else if (hcnt >= ack_delay && !drop_ack) begin
        halt_ack = halt_req;
      end else if (hcnt >= ack_delay && nrun == 0) begin
        halt_ack = halt_req;
      end
      if (pready) begin
        saw_ready  = 1'b1;
        got_slverr = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; halt_ack = 1'b0;
        break;
      end
    end
    if (!saw_ready) begin
      psel = 1'b0; penable = 1'b0; halt_ack = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 16'h0000; pwdata = 8'h00; halt_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({prdata, pready, pslverr, halt_req, dbg_active, uc_step, uc_addr, uc_write, dbg_bus_out} !== 29'd0) begin
      failures++;
      $display("FAIL reset_outputs got prdata=%h pready=%b pslverr=%b halt=%b act=%b step=%0d addr=%h wr=%b bus=%h expected all zero",
               prdata, pready, pslverr, halt_req, dbg_active, uc_step, uc_addr, uc_write, dbg_bus_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    run_xfer(16'h0001, 1'b1, 8'h5A, 2, 1'b0);
    checks++;
    if (nrun !== 1 || bus0 !== 8'h5A) begin
      failures++; $display("FAIL write_run got nrun=%0d bus=%h expected 1 / 5a", nrun, bus0);
    end
    checks++;
    if (saw_ready !== 1'b1 || got_slverr !== 1'b0 || first_pready !== 1'b0) begin
      failures++; $display("FAIL write_complete got ready=%b slverr=%b first=%b expected 1 0 0", saw_ready, got_slverr, first_pready);
    end
    @(negedge clk);
    checks++;
    if (halt_req !== 1'b0 || pready !== 1'b0 || uc_step !== 2'd0 || uc_write !== 1'b1) begin
      failures++; $display("FAIL write_release got halt=%b pready=%b step=%0d wr=%b expected 0 0 0 1", halt_req, pready, uc_step, uc_write);
    end
  endtask

  task automatic test_read_bus();
    run_xfer(16'h000A, 1'b0, 8'h00, 1, 1'b1);
    checks++;
    if (nrun !== 2 || bus0 !== 8'h02) begin
      failures++; $display("FAIL read_bus_run got nrun=%0d bus0=%h expected 2 / 02", nrun, bus0);
    end
    checks++;
    if (saw_ready !== 1'b1 || got_slverr !== 1'b0 || prdata !== 8'h33) begin
      failures++; $display("FAIL read_bus_data got ready=%b slverr=%b prdata=%h expected 1 0 33", saw_ready, got_slverr, prdata);
    end
  endtask

  task automatic test_read_outreg();
    run_xfer(16'h0007, 1'b0, 8'h00, 0, 1'b0);
    checks++;
    if (nrun !== 1 || saw_ready !== 1'b1 || got_slverr !== 1'b0 || prdata !== 8'hC4) begin
      failures++; $display("FAIL read_outreg got nrun=%0d ready=%b slverr=%b prdata=%h expected 1 1 0 c4", nrun, saw_ready, got_slverr, prdata);
    end
  endtask

  task automatic test_psel_drop();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0007;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    checks++;
    if (halt_req !== 1'b1) begin
      failures++; $display("FAIL drop_halt_req got %b expected 1", halt_req);
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    checks++;
    if (halt_req !== 1'b0 || pready !== 1'b0 || prdata !== 8'hC4) begin
      failures++; $display("FAIL drop_release got halt=%b pready=%b prdata=%h expected 0 0 c4", halt_req, pready, prdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_step_exhaust();
    run_xfer(16'h001F, 1'b0, 8'h00, 0, 1'b0);
    checks++;
    if (nrun !== 4 || saw_ready !== 1'b1 || got_slverr !== 1'b1 || prdata !== 8'hC4) begin
      failures++; $display("FAIL exhaust got nrun=%0d ready=%b slverr=%b prdata=%h expected 4 1 1 c4", nrun, saw_ready, got_slverr, prdata);
    end
    checks++;
    if (run_when_free !== 1'b0) begin
      failures++; $display("FAIL exhaust_rom_exposed got %b expected 0", run_when_free);
    end
  endtask

  task automatic test_addr_err();
    run_xfer(16'h0120, 1'b0, 8'h00, 0, 1'b0);
    checks++;
    if (halt_seen !== 1'b0 || nrun !== 0) begin
      failures++; $display("FAIL addr_err_halt got halt_seen=%b nrun=%0d expected 0 0", halt_seen, nrun);
    end
    checks++;
    if (saw_ready !== 1'b1 || got_slverr !== 1'b1 || first_pready !== 1'b0 || prdata !== 8'hC4) begin
      failures++; $display("FAIL addr_err_resp got ready=%b slverr=%b first=%b prdata=%h expected 1 1 0 c4", saw_ready, got_slverr, first_pready, prdata);
    end
  endtask

  task automatic test_reset_mid_run();
    logic seen = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0008; pwdata = 8'hE1;
    @(posedge clk); #1;
    penable = 1'b1; halt_ack = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = dbg_active;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL midrun_reach got dbg_active=0 expected RUN within 10 cycles");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({prdata, pready, pslverr, halt_req, dbg_active, uc_step, uc_addr, uc_write, dbg_bus_out} !== 29'd0) begin
      failures++;
      $display("FAIL midrun_reset got prdata=%h pready=%b pslverr=%b halt=%b act=%b step=%0d addr=%h wr=%b bus=%h expected all zero",
               prdata, pready, pslverr, halt_req, dbg_active, uc_step, uc_addr, uc_write, dbg_bus_out);
    end
    psel = 1'b0; penable = 1'b0; halt_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_xfer(16'h0002, 1'b0, 8'h00, 1, 1'b0);
    checks++;
    if (nrun !== 1 || saw_ready !== 1'b1 || got_slverr !== 1'b0 || prdata !== 8'h99) begin
      failures++; $display("FAIL post_reset_read got nrun=%0d ready=%b slverr=%b prdata=%h expected 1 1 0 99", nrun, saw_ready, got_slverr, prdata);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_bus();
    test_read_outreg();
    test_psel_drop();
    test_step_exhaust();
    test_addr_err();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
